// File: rtl/game_sequencer.sv
// Memory-game sequencer: grows a random 4-LED pattern one step per round, plays it back,
// then checks the player's button presses against it with a per-press timeout.
module game_sequencer #(
   parameter int LEN_MAX = 8,
   parameter int TIMEOUT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       blink_tick,
   input  logic       read_tick,
   input  logic       start,
   input  logic [3:0] btn,
   input  logic [1:0] rnd,
   output logic [3:0] led,
   output logic       busy,
   output logic       win,
   output logic       lose,
   output logic [3:0] level
);

   localparam int IW = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [3:0]    LEVEL_MAX = 4'(LEN_MAX);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE
   } stateType;

   stateType       stateReg, stateNext;
   logic [3:0]     levelReg, levelNext;
   logic [3:0]     idxReg, idxNext;
   logic [TW-1:0]  toReg, toNext;
   logic [3:0]     prevReg, prevNext;
   logic           flagReg, flagNext;
   logic [1:0]     patternReg [LEN_MAX];
   logic [1:0]     patternNext [LEN_MAX];

   logic           lastIdx;
   logic [3:0]     expected;
   logic [TW-1:0]  toInc;

   function automatic logic [3:0] onehot(input logic [1:0] v);
      return 4'b0001 << v;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateReg <= IDLE;
         levelReg <= '0;
         idxReg   <= '0;
         toReg    <= '0;
         prevReg  <= '0;
         flagReg  <= 1'b0;
         for (int i = 0; i < LEN_MAX; i++) patternReg[i] <= '0;
      end else begin
         stateReg <= stateNext;
         levelReg <= levelNext;
         idxReg   <= idxNext;
         toReg    <= toNext;
         prevReg  <= prevNext;
         flagReg  <= flagNext;
         for (int i = 0; i < LEN_MAX; i++) patternReg[i] <= patternNext[i];
      end
   end

   assign lastIdx  = (idxReg == levelReg - 4'd1);
   assign expected = onehot(patternReg[IW'(idxReg)]);
   assign toInc    = toReg + 1'b1;

   always_comb begin
      stateNext = stateReg;
      levelNext = levelReg;
      idxNext   = idxReg;
      toNext    = toReg;
      prevNext  = prevReg;
      flagNext  = flagReg;
      for (int i = 0; i < LEN_MAX; i++) patternNext[i] = patternReg[i];

      case (stateReg)
         IDLE, WIN, LOSE: begin
            if (blink_tick && stateReg != IDLE) flagNext = ~flagReg;
            if (start) begin
               levelNext = 4'd1;
               flagNext  = 1'b0;
               stateNext = GEN;
               for (int i = 0; i < LEN_MAX; i++) patternNext[i] = '0;
            end
         end
         GEN: begin
            patternNext[IW'(levelReg - 4'd1)] = rnd;
            idxNext   = '0;
            stateNext = SHOW_ON;
         end
         SHOW_ON: begin
            if (blink_tick) stateNext = SHOW_OFF;
         end
         SHOW_OFF: begin
            if (blink_tick) begin
               if (lastIdx) begin
                  idxNext   = '0;
                  toNext    = '0;
                  stateNext = INPUT;
               end else begin
                  idxNext   = idxReg + 4'd1;
                  stateNext = SHOW_ON;
               end
            end
         end
         INPUT: begin
            // A read_tick swallows any coincident blink_tick so timeout never races a press.
            if (read_tick) begin
               prevNext = btn;
               if (btn != 4'b0000 && prevReg == 4'b0000) begin
                  if (btn != expected) begin
                     stateNext = LOSE;
                  end else if (!lastIdx) begin
                     idxNext = idxReg + 4'd1;
                     toNext  = '0;
                  end else if (levelReg == LEVEL_MAX) begin
                     stateNext = WIN;
                  end else begin
                     levelNext = levelReg + 4'd1;
                     stateNext = GEN;
                  end
               end
            end else if (blink_tick) begin
               if (toInc == TO_LIMIT) stateNext = LOSE;
               else toNext = toInc;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      led  = 4'b0000;
      busy = 1'b0;
      win  = 1'b0;
      lose = 1'b0;
      case (stateReg)
         GEN:      busy = 1'b1;
         SHOW_ON:  begin busy = 1'b1; led = expected; end
         SHOW_OFF: busy = 1'b1;
         INPUT:    begin busy = 1'b1; led = prevReg; end
         WIN:      begin win = 1'b1; led = flagReg ? 4'b1111 : 4'b0000; end
         LOSE:     begin lose = 1'b1; led = flagReg ? 4'b1001 : 4'b0000; end
         default:  ;
      endcase
   end

   assign level = levelReg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench: instance A uses default parameters, instance B uses LEN_MAX=2 for the win path.
module tb_game_sequencer;

   logic       clk = 1'b0;
   logic       rst, blink_tick, read_tick, start;
   logic [3:0] btn;
   logic [1:0] rnd;
   logic [3:0] ledA, levelA, ledB, levelB;
   logic       busyA, winA, loseA, busyB, winB, loseB;
   int         numChecks = 0;
   int         numErrors = 0;

   always #5 clk = ~clk;

   game_sequencer dutA (
      .clk(clk), .rst(rst), .blink_tick(blink_tick), .read_tick(read_tick), .start(start),
      .btn(btn), .rnd(rnd), .led(ledA), .busy(busyA), .win(winA), .lose(loseA), .level(levelA)
   );

   game_sequencer #(.LEN_MAX(2), .TIMEOUT(10)) dutB (
      .clk(clk), .rst(rst), .blink_tick(blink_tick), .read_tick(read_tick), .start(start),
      .btn(btn), .rnd(rnd), .led(ledB), .busy(busyB), .win(winB), .lose(loseB), .level(levelB)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulseBlink();
      blink_tick = 1'b1;
      cyc(1);
      blink_tick = 1'b0;
   endtask

   task automatic pulseRead(input logic [3:0] b);
      btn = b;
      read_tick = 1'b1;
      cyc(1);
      read_tick = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; start = 1'b0; blink_tick = 1'b0; read_tick = 1'b0; btn = 4'b0; rnd = 2'd0;
      cyc(2);
      checkVal("rst_led", ledA, 4'b0000);
      checkVal("rst_busy", busyA, 1'b0);
      checkVal("rst_win", winA, 1'b0);
      checkVal("rst_lose", loseA, 1'b0);
      checkVal("rst_level", levelA, 4'd0);
      rst = 1'b1;
      cyc(1);

      // First round, pattern {2}
      rnd = 2'd2; start = 1'b1; cyc(1); start = 1'b0;
      checkVal("gen_level", levelA, 4'd1);
      checkVal("gen_busy", busyA, 1'b1);
      cyc(1);
      checkVal("show_led", ledA, 4'b0100);
      pulseBlink();
      checkVal("showoff_led", ledA, 4'b0000);
      pulseBlink();
      checkVal("input_busy", busyA, 1'b1);
      rnd = 2'd0;
      pulseRead(4'b0100);
      checkVal("l2_level", levelA, 4'd2);
      checkVal("l2_gen_led", ledA, 4'b0000);
      cyc(1);
      checkVal("l2_show0", ledA, 4'b0100);
      pulseBlink(); pulseBlink();
      checkVal("l2_show1", ledA, 4'b0001);
      pulseBlink(); pulseBlink();
      checkVal("input_echo", ledA, 4'b0100);

      // Correct first press, then a multi-bit wrong press
      pulseRead(4'b0000); pulseRead(4'b0100);
      checkVal("l2_press0_busy", busyA, 1'b1);
      checkVal("l2_press0_lose", loseA, 1'b0);
      pulseRead(4'b0000); pulseRead(4'b0011);
      checkVal("lose_flag", loseA, 1'b1);
      checkVal("lose_busy", busyA, 1'b0);
      checkVal("lose_led0", ledA, 4'b0000);
      pulseBlink();
      checkVal("lose_led1", ledA, 4'b1001);
      pulseBlink();
      checkVal("lose_led2", ledA, 4'b0000);
      pulseBlink();
      checkVal("lose_led3", ledA, 4'b1001);

      // Timeout: 9 idle ticks then a correct press survives
      rnd = 2'd1; start = 1'b1; cyc(1); start = 1'b0;
      checkVal("restart_level", levelA, 4'd1);
      checkVal("restart_lose", loseA, 1'b0);
      cyc(1);
      checkVal("restart_show", ledA, 4'b0010);
      pulseBlink(); pulseBlink();
      repeat (9) pulseBlink();
      checkVal("to9_lose", loseA, 1'b0);
      rnd = 2'd3;
      pulseRead(4'b0000); pulseRead(4'b0010);
      checkVal("to9_level", levelA, 4'd2);
      checkVal("to9_nolose", loseA, 1'b0);
      cyc(1);
      pulseBlink(); pulseBlink();
      checkVal("to_show1", ledA, 4'b1000);
      pulseBlink(); pulseBlink();
      for (int i = 1; i <= 10; i++) begin
         pulseBlink();
         if (i >= 9) checkVal($sformatf("to_tick%0d", i), loseA, (i == 10) ? 1'b1 : 1'b0);
      end

      // Reach level 3, abort with reset during SHOW_OFF
      rnd = 2'd0; start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      pulseBlink(); pulseBlink();
      pulseRead(4'b0000); pulseRead(4'b0001);
      cyc(1);
      repeat (4) pulseBlink();
      pulseRead(4'b0000); pulseRead(4'b0001);
      pulseRead(4'b0000); pulseRead(4'b0001);
      cyc(1);
      pulseBlink();
      checkVal("l3_level", levelA, 4'd3);
      checkVal("l3_busy", busyA, 1'b1);
      #2 rst = 1'b0;
      #1;
      checkVal("async_level", levelA, 4'd0);
      checkVal("async_busy", busyA, 1'b0);
      checkVal("async_led", ledA, 4'b0000);
      cyc(1);
      rst = 1'b1; rnd = 2'd1; start = 1'b1; cyc(1); start = 1'b0;
      checkVal("post_rst_level", levelA, 4'd1);
      cyc(1);
      checkVal("post_rst_show", ledA, 4'b0010);

      // Win path on the LEN_MAX=2 instance
      rst = 1'b0; cyc(1); rst = 1'b1;
      rnd = 2'd2; start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      pulseBlink(); pulseBlink();
      rnd = 2'd1;
      pulseRead(4'b0100);
      checkVal("b_level2", levelB, 4'd2);
      cyc(1);
      repeat (4) pulseBlink();
      pulseRead(4'b0000); pulseRead(4'b0100);
      pulseRead(4'b0000); pulseRead(4'b0010);
      checkVal("b_win", winB, 1'b1);
      checkVal("b_win_busy", busyB, 1'b0);
      checkVal("b_win_led0", ledB, 4'b0000);
      pulseBlink();
      checkVal("b_win_led1", ledB, 4'b1111);
      pulseBlink();
      checkVal("b_win_led2", ledB, 4'b0000);
      start = 1'b1; cyc(1); start = 1'b0;
      checkVal("b_restart_level", levelB, 4'd1);
      checkVal("b_restart_busy", busyB, 1'b1);
      checkVal("b_restart_win", winB, 1'b0);

      $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
      $finish;
   end

endmodule
